// File: rtl/adam_fabric_demux.sv
// 1:N AXI-Lite demultiplexer with a window address map, per-direction outstanding tracking and ADAM pause.
// Optional macro ADAM_FABRIC_DEMUX_ERRCNT_EN adds a saturating decode-error counter output err_cnt.
module adam_fabric_demux #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             NO_MSTS    = 4,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter int unsigned             WIN_LSB    = 12,
    parameter int unsigned             MAX_TRANS  = 7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pause_req,
    output logic                        pause_ack,
`ifdef ADAM_FABRIC_DEMUX_ERRCNT_EN
    output logic [15:0]                 err_cnt,
`endif
    input  logic [ADDR_WIDTH-1:0]       slv_aw_addr,
    input  logic [2:0]                  slv_aw_prot,
    input  logic                        slv_aw_valid,
    output logic                        slv_aw_ready,
    input  logic [DATA_WIDTH-1:0]       slv_w_data,
    input  logic [DATA_WIDTH/8-1:0]     slv_w_strb,
    input  logic                        slv_w_valid,
    output logic                        slv_w_ready,
    output logic [1:0]                  slv_b_resp,
    output logic                        slv_b_valid,
    input  logic                        slv_b_ready,
    input  logic [ADDR_WIDTH-1:0]       slv_ar_addr,
    input  logic [2:0]                  slv_ar_prot,
    input  logic                        slv_ar_valid,
    output logic                        slv_ar_ready,
    output logic [DATA_WIDTH-1:0]       slv_r_data,
    output logic [1:0]                  slv_r_resp,
    output logic                        slv_r_valid,
    input  logic                        slv_r_ready,
    output logic [ADDR_WIDTH-1:0]       msts_aw_addr  [NO_MSTS],
    output logic [2:0]                  msts_aw_prot  [NO_MSTS],
    output logic [NO_MSTS-1:0]          msts_aw_valid,
    input  logic [NO_MSTS-1:0]          msts_aw_ready,
    output logic [DATA_WIDTH-1:0]       msts_w_data   [NO_MSTS],
    output logic [DATA_WIDTH/8-1:0]     msts_w_strb   [NO_MSTS],
    output logic [NO_MSTS-1:0]          msts_w_valid,
    input  logic [NO_MSTS-1:0]          msts_w_ready,
    input  logic [1:0]                  msts_b_resp   [NO_MSTS],
    input  logic [NO_MSTS-1:0]          msts_b_valid,
    output logic [NO_MSTS-1:0]          msts_b_ready,
    output logic [ADDR_WIDTH-1:0]       msts_ar_addr  [NO_MSTS],
    output logic [2:0]                  msts_ar_prot  [NO_MSTS],
    output logic [NO_MSTS-1:0]          msts_ar_valid,
    input  logic [NO_MSTS-1:0]          msts_ar_ready,
    input  logic [DATA_WIDTH-1:0]       msts_r_data   [NO_MSTS],
    input  logic [1:0]                  msts_r_resp   [NO_MSTS],
    input  logic [NO_MSTS-1:0]          msts_r_valid,
    output logic [NO_MSTS-1:0]          msts_r_ready
);
    localparam int unsigned IW = $clog2(NO_MSTS + 1);
    localparam int unsigned CW = $clog2(MAX_TRANS + 1);
    localparam logic [IW-1:0] ERR_IDX = IW'(NO_MSTS);
    localparam logic [1:0]    DECERR  = 2'b11;

    logic [CW-1:0] wr_cnt, wr_cnt_nxt, w_credit, w_credit_nxt, err_b_cnt, rd_cnt, rd_cnt_nxt, err_r_cnt;
    logic [IW-1:0] wr_tgt, rd_tgt, aw_idx, ar_idx;
    logic          aw_pend, ar_pend, aw_fwd, ar_fwd, aw_err, ar_err, w_err, r_err;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_tgt_ready, ar_tgt_ready;

    function automatic logic [IW-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = (addr - BASE_ADDR) >> WIN_LSB;
        if (addr >= BASE_ADDR && off < ADDR_WIDTH'(NO_MSTS)) decode = IW'(off);
        else                                                   decode = ERR_IDX;
    endfunction

    // Request channels: a forwarded-but-unaccepted valid bypasses pause and lock gating
    always_comb begin
        aw_idx       = decode(slv_aw_addr);
        ar_idx       = decode(slv_ar_addr);
        aw_err       = (aw_idx == ERR_IDX);
        ar_err       = (ar_idx == ERR_IDX);
        aw_fwd       = rst_n && slv_aw_valid && (aw_pend || (!pause_req && wr_cnt < CW'(MAX_TRANS)
                                                 && (wr_cnt == '0 || aw_idx == wr_tgt)));
        ar_fwd       = rst_n && slv_ar_valid && (ar_pend || (!pause_req && rd_cnt < CW'(MAX_TRANS)
                                                 && (rd_cnt == '0 || ar_idx == rd_tgt)));
        aw_tgt_ready = aw_err;
        ar_tgt_ready = ar_err;
        for (int i = 0; i < int'(NO_MSTS); i++) begin
            msts_aw_addr[i]  = slv_aw_addr;
            msts_aw_prot[i]  = slv_aw_prot;
            msts_aw_valid[i] = aw_fwd && (aw_idx == IW'(i));
            msts_ar_addr[i]  = slv_ar_addr;
            msts_ar_prot[i]  = slv_ar_prot;
            msts_ar_valid[i] = ar_fwd && (ar_idx == IW'(i));
            if (aw_idx == IW'(i)) aw_tgt_ready = msts_aw_ready[i];
            if (ar_idx == IW'(i)) ar_tgt_ready = msts_ar_ready[i];
        end
        slv_aw_ready = aw_fwd && aw_tgt_ready;
        slv_ar_ready = ar_fwd && ar_tgt_ready;
        aw_hs        = slv_aw_valid && slv_aw_ready;
        ar_hs        = slv_ar_valid && slv_ar_ready;
    end

    // W, B and R follow the locked target of their direction
    always_comb begin
        w_err       = (wr_tgt == ERR_IDX);
        r_err       = (rd_tgt == ERR_IDX);
        slv_w_ready = rst_n && (w_credit != '0) && w_err;
        slv_b_valid = (wr_cnt != '0) && w_err && (err_b_cnt != '0);
        slv_b_resp  = DECERR;
        slv_r_valid = (rd_cnt != '0) && r_err && (err_r_cnt != '0);
        slv_r_resp  = DECERR;
        slv_r_data  = '0;
        for (int i = 0; i < int'(NO_MSTS); i++) begin
            msts_w_data[i]  = slv_w_data;
            msts_w_strb[i]  = slv_w_strb;
            msts_w_valid[i] = rst_n && slv_w_valid && (w_credit != '0) && (wr_tgt == IW'(i));
            msts_b_ready[i] = rst_n && slv_b_ready && (wr_cnt != '0) && (wr_tgt == IW'(i));
            msts_r_ready[i] = rst_n && slv_r_ready && (rd_cnt != '0) && (rd_tgt == IW'(i));
            if (wr_tgt == IW'(i)) begin
                slv_w_ready = rst_n && (w_credit != '0) && msts_w_ready[i];
                slv_b_valid = (wr_cnt != '0) && msts_b_valid[i];
                slv_b_resp  = msts_b_resp[i];
            end
            if (rd_tgt == IW'(i)) begin
                slv_r_valid = (rd_cnt != '0) && msts_r_valid[i];
                slv_r_resp  = msts_r_resp[i];
                slv_r_data  = msts_r_data[i];
            end
        end
        w_hs         = slv_w_valid && slv_w_ready;
        b_hs         = slv_b_valid && slv_b_ready;
        r_hs         = slv_r_valid && slv_r_ready;
        wr_cnt_nxt   = wr_cnt + CW'(aw_hs) - CW'(b_hs);
        w_credit_nxt = w_credit + CW'(aw_hs) - CW'(w_hs);
        rd_cnt_nxt   = rd_cnt + CW'(ar_hs) - CW'(r_hs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            w_credit  <= '0;
            err_b_cnt <= '0;
            rd_cnt    <= '0;
            err_r_cnt <= '0;
            wr_tgt    <= '0;
            rd_tgt    <= '0;
            aw_pend   <= 1'b0;
            ar_pend   <= 1'b0;
            pause_ack <= 1'b1;
        end else begin
            wr_cnt    <= wr_cnt_nxt;
            w_credit  <= w_credit_nxt;
            rd_cnt    <= rd_cnt_nxt;
            err_b_cnt <= err_b_cnt + CW'(w_hs && w_err) - CW'(b_hs && w_err);
            err_r_cnt <= err_r_cnt + CW'(ar_hs && ar_err) - CW'(r_hs && r_err);
            if (aw_hs) wr_tgt <= aw_idx;
            if (ar_hs) rd_tgt <= ar_idx;
            aw_pend   <= aw_fwd && !aw_hs;
            ar_pend   <= ar_fwd && !ar_hs;
            pause_ack <= pause_req && (wr_cnt_nxt == '0) && (rd_cnt_nxt == '0) && (w_credit_nxt == '0);
        end
    end

`ifdef ADAM_FABRIC_DEMUX_ERRCNT_EN
    logic [16:0] err_sum;
    always_comb err_sum = 17'(err_cnt) + 17'(aw_hs && aw_err) + 17'(ar_hs && ar_err);

    // Saturating count of decode-error request handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt <= '0;
        else        err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif

endmodule
